// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-back path.
//   reg_num_t  : 5-bit architectural register number
//   word_t     : 32-bit data word
//   wb_entry_t : one queued write-back {dst, data}
//   reg_onehot : one-hot decode of a register number into a 32-bit mask
package regfile_wb_arbiter_pkg;

    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0]  reg_num_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_num_t dst;
        word_t    data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_num_t r);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small load-return queue of wb_entry_t.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, din     : enqueue din (ignored when full)
//   pop, dout     : dequeue; dout always shows the head entry
//   full, empty   : occupancy flags, from registered state only
//   entry_valid   : per-slot occupied flag
//   entry_dst     : per-slot destination register (meaningful only where valid)
// Storage is a flat register array so every slot's dst is visible at once
// for the pending-load mask.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             din,
    output wb_entry_t             dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [DEPTH-1:0][4:0] entry_dst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers are PTR_W bits wide, so with DEPTH a power of two they wrap
    // modulo DEPTH without explicit compare logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A slot is written and read in the same cycle only when the queue is
    // full or empty, and the guards above exclude both, so set/clear never
    // collide on one slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_ptr_q == PTR_W'(i))) begin
                    valid_q[i] <= 1'b1;
                end else if (do_pop && (rd_ptr_q == PTR_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: a slot is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign entry_valid = valid_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dst
            assign entry_dst[gi] = mem_q[gi].dst;
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: single write-port initiator for the 32x32 register file.
// Merges single-cycle ALU results with variable-latency load returns.
// Load returns are buffered in wb_fifo.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   alu_valid/alu_dst/alu_data   : ALU result (no ready; upstream honours alu_stall)
//   ld_valid/ld_ready/ld_dst/ld_data : load return, valid/ready handshake
//   alu_stall                    : registered; asks upstream to withhold ALU results
//   pend_mask                    : bit r set while a queued load targets r
//   wr_num/wr_data/wr_en         : registered regfile write port
// ALU results win the port; a queued load that loses for STARVE_MAX cycles
// raises alu_stall until the queue drains.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_dst,
    input  logic [31:0] ld_data,
    output logic        alu_stall,
    output logic [31:0] pend_mask,
    output logic [4:0]  wr_num,
    output logic [31:0] wr_data,
    output logic        wr_en
);

    localparam int unsigned STARVE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX - 1);

    // FIFO interface
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    wb_entry_t             fifo_din;
    wb_entry_t             fifo_dout;
    logic [DEPTH-1:0]      entry_valid;
    logic [DEPTH-1:0][4:0] entry_dst;

    // Arbitration
    logic alu_issue;

    // State
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                alu_stall_q,  alu_stall_d;
    logic                wr_en_q,      wr_en_d;
    reg_num_t            wr_num_q,     wr_num_d;
    word_t               wr_data_q,    wr_data_d;

    // ld_ready depends on stored occupancy only, so a pop in the same cycle
    // does not reopen a full queue.
    assign ld_ready = !fifo_full;

    // Loads to r0 complete the handshake but never enter the queue.
    assign fifo_push     = ld_valid && ld_ready && (ld_dst != '0);
    assign fifo_din.dst  = ld_dst;
    assign fifo_din.data = ld_data;

    // ALU results to r0, or presented while stalled, are dropped and leave
    // the cycle free for the queue head.
    assign alu_issue = alu_valid && (alu_dst != '0) && !alu_stall_q;
    assign fifo_pop  = !alu_issue && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .din         (fifo_din),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_dst   (entry_dst)
    );

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask = pend_mask | reg_onehot(entry_dst[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Starvation: count cycles the head waits behind the ALU. The stall is
    // raised once the wait reaches STARVE_MAX and held until the queue is
    // seen empty, so a burst of returns drains completely.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        alu_stall_d  = alu_stall_q;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (fifo_empty) begin
            alu_stall_d = 1'b0;
        end else if (!fifo_pop && (starve_cnt_q == STARVE_LIMIT)) begin
            alu_stall_d = 1'b1;
        end
    end

    // Write port: wr_num/wr_data keep their last values on idle cycles.
    always_comb begin
        wr_en_d   = alu_issue || fifo_pop;
        wr_num_d  = wr_num_q;
        wr_data_d = wr_data_q;
        if (alu_issue) begin
            wr_num_d  = alu_dst;
            wr_data_d = alu_data;
        end else if (fifo_pop) begin
            wr_num_d  = fifo_dout.dst;
            wr_data_d = fifo_dout.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_num_q     <= '0;
            wr_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
            wr_en_q      <= wr_en_d;
            wr_num_q     <= wr_num_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign alu_stall = alu_stall_q;
    assign wr_en     = wr_en_q;
    assign wr_num    = wr_num_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Stimulus is driven on the falling edge and
// each expected write is queued by hand in issue order; a monitor on the
// falling edge pops and compares whenever wr_en is high.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } exp_wr_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dst;
    logic [31:0] ld_data;
    logic        alu_stall;
    logic [31:0] pend_mask;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic        wr_en;

    int total = 0;
    int bad   = 0;
    exp_wr_t exp_q[$];
    logic [31:0] rf [32];

    regfile_wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_dst    (ld_dst),
        .ld_data   (ld_data),
        .alu_stall (alu_stall),
        .pend_mask (pend_mask),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [31:0] v);
        exp_wr_t e;
        e.dst  = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus, plus the upstream-protocol checks on what was driven.
    task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic lv, input logic [4:0] ldd, input logic [31:0] ldat);
        @(negedge clk);
        alu_valid = av;
        alu_dst   = ad;
        alu_data  = adat;
        ld_valid  = lv;
        ld_dst    = ldd;
        ld_data   = ldat;
        total++;
        if (alu_valid && alu_stall) begin
            bad++;
            $display("FAIL proto_stall: alu_valid=1 while alu_stall=1, required alu_valid=0");
        end
        total++;
        if (alu_valid && (alu_dst != 5'd0) && pend_mask[alu_dst]) begin
            bad++;
            $display("FAIL proto_waw: alu_dst=%0d with pend_mask=%h, required no pending load", alu_dst, pend_mask);
        end
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (wr_en) begin
            exp_wr_t e;
            $display("wr r%0d = %h", wr_num, wr_data);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write", wr_num, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_num !== e.dst || wr_data !== e.data) begin
                    bad++;
                    $display("FAIL wb_order: got r%0d=%h, required r%0d=%h", wr_num, wr_data, e.dst, e.data);
                end
            end
            rf[wr_num] = wr_data;
        end
    end

    initial begin
        logic [13:0] stall_v;
        alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_dst  = '0; ld_data  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_wr_num",    {27'd0, wr_num},    32'd0);
        chk("rst_wr_data",   wr_data,            32'd0);
        chk("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_ld_ready",  {31'd0, ld_ready},  32'd1);
        chk("rst_pend_mask", pend_mask,          32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ALU only
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd5, 32'hDEADBEEF);
        idle();
        chk("t1_wr_en",   {31'd0, wr_en},  32'd1);
        chk("t1_wr_num",  {27'd0, wr_num}, 32'd5);
        chk("t1_wr_data", wr_data,         32'hDEADBEEF);
        idle();
        chk("t1_idle_wr_en",  {31'd0, wr_en},  32'd0);
        chk("t1_hold_wr_num", {27'd0, wr_num}, 32'd5);
        chk("t1_rf_r5",       rf[5],           32'hDEADBEEF);

        // 2: loads only, each popped the cycle after it is pushed
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'd1);
        expect_wr(5'd1, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'd2);
        expect_wr(5'd2, 32'd2);
        chk("t2_pend_a", pend_mask, 32'h2);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'd3);
        expect_wr(5'd3, 32'd3);
        chk("t2_pend_b", pend_mask, 32'h4);
        idle();
        chk("t2_pend_c", pend_mask, 32'h8);
        idle();
        chk("t2_pend_d", pend_mask, 32'h0);
        idle();

        // 3: ALU to r7 every cycle while four loads fill the queue
        drive(1'b1, 5'd7, 32'h700, 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd7, 32'h700);
        drive(1'b1, 5'd7, 32'h701, 1'b1, 5'd11, 32'hA1);
        expect_wr(5'd7, 32'h701);
        chk("t3_pend_1", pend_mask, 32'h0000_0400);
        drive(1'b1, 5'd7, 32'h702, 1'b1, 5'd12, 32'hA2);
        expect_wr(5'd7, 32'h702);
        chk("t3_pend_2", pend_mask, 32'h0000_0C00);
        drive(1'b1, 5'd7, 32'h703, 1'b1, 5'd13, 32'hA3);
        expect_wr(5'd7, 32'h703);
        chk("t3_pend_3", pend_mask, 32'h0000_1C00);
        drive(1'b1, 5'd7, 32'h704, 1'b1, 5'd14, 32'hA4);
        expect_wr(5'd7, 32'h704);
        chk("t3_pend_4", pend_mask, 32'h0000_3C00);
        chk("t3_full_ready", {31'd0, ld_ready}, 32'd0);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd11, 32'hA1);
        expect_wr(5'd12, 32'hA2);
        expect_wr(5'd13, 32'hA3);
        expect_wr(5'd14, 32'hA4);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hA4);
        chk("t3_still_full", {31'd0, ld_ready}, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hA4);
        chk("t3_reopen", {31'd0, ld_ready}, 32'd1);
        idle();
        chk("t3_pend_5", pend_mask, 32'h0000_7000);
        for (int i = 0; i < 4; i++) idle();
        chk("t3_pend_end", pend_mask, 32'h0);

        // 4: starvation. Stall rises after 8 losing cycles (before step 9),
        // the load drains in step 9, stall drops before step 11.
        stall_v = 14'b00_0110_0000_0000;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                drive(1'b1, 5'd8, 32'h800, 1'b1, 5'd20, 32'h20);
            end else begin
                drive(!stall_v[i], 5'd8, 32'h800 + 32'(i), 1'b0, 5'd0, 32'h0);
            end
            chk($sformatf("t4_stall_%0d", i), {31'd0, alu_stall}, {31'd0, stall_v[i]});
            if (!stall_v[i]) expect_wr(5'd8, 32'h800 + 32'(i));
            if (i == 9) begin
                expect_wr(5'd20, 32'h20);
                chk("t4_pend_held", pend_mask, 32'h0010_0000);
            end
            if (i == 10) chk("t4_pend_drained", pend_mask, 32'h0);
        end
        idle();
        idle();

        // 5: r0 destinations
        drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd3, 32'h33);
        expect_wr(5'd9, 32'h90);
        expect_wr(5'd3, 32'h33);
        drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'h0);
        chk("t5_pend_q", pend_mask, 32'h8);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD0);
        chk("t5_ld_wr_num", {27'd0, wr_num}, 32'd3);
        chk("t5_ready_r0", {31'd0, ld_ready}, 32'd1);
        idle();
        chk("t5_pend_r0", pend_mask, 32'h0);
        idle();
        chk("t5_no_wr", {31'd0, wr_en}, 32'd0);
        idle();

        // 6: reset with two loads queued
        drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd4, 32'h44);
        expect_wr(5'd11, 32'hB0);
        drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd5, 32'h55);
        expect_wr(5'd11, 32'hB1);
        drive(1'b1, 5'd11, 32'hB2, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd11, 32'hB2);
        idle();
        chk("t6_pend_pre", pend_mask, 32'h30);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en",  {31'd0, wr_en},     32'd0);
        chk("t6_rst_ready",  {31'd0, ld_ready},  32'd1);
        chk("t6_rst_pend",   pend_mask,          32'd0);
        chk("t6_rst_stall",  {31'd0, alu_stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
